// File: rtl/flappy_pkg.sv
// Shared constants, state type and gap helper
// for the flappy game blocks.
package flappy_pkg;

  localparam int SCREEN_W  = 640;
  localparam int BIRD_X    = 100;
  localparam int SPRITE_W  = 34;
  localparam int SPRITE_H  = 24;
  localparam int TICK_BITS = 20;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_e;

  // Folds an 8-bit random value into 0..rng.
  function automatic logic [7:0] gap_off(
    input logic [7:0] r,
    input logic [7:0] rng
  );
    return (r > rng) ? 8'(r - rng - 8'd1) : r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR,
// shared by the randomised blocks.
module lfsr16
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  assign q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_MASK)
                      : (q_q >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_field.sv
// Pipe obstacle generator: scrolls, respawns,
// scores passed pipes and flags bird overlap.
module pipe_field #(
  parameter int NUM_PIPES    = 3,
  parameter int SCREEN_W     = flappy_pkg::SCREEN_W,
  parameter int PIPE_W       = 52,
  parameter int PIPE_SPACING = 220,
  parameter int GAP_H        = 120,
  parameter int GAP_MIN_Y    = 60,
  parameter int GAP_MAX_Y    = 300,
  parameter int SCROLL_SPEED = 2,
  parameter int TICK_BITS    = flappy_pkg::TICK_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alive,
  input  logic [9:0]               bird_y,
  output logic                     collision,
  output logic [11*NUM_PIPES-1:0]  pipe_x,
  output logic [10*NUM_PIPES-1:0]  gap_y,
  output logic [7:0]               score
);

  localparam int RANGE = GAP_MAX_Y - GAP_MIN_Y;

  localparam logic [11:0] SPD  = 12'(SCROLL_SPEED);
  localparam logic [11:0] WRAP = 12'(NUM_PIPES * PIPE_SPACING);
  localparam logic [11:0] PW   = 12'(PIPE_W);
  localparam logic [11:0] BX   = 12'(flappy_pkg::BIRD_X);
  localparam logic [11:0] BXR  =
    12'(flappy_pkg::BIRD_X + flappy_pkg::SPRITE_W);
  localparam logic [11:0] SH   = 12'(flappy_pkg::SPRITE_H);
  localparam logic [11:0] GH   = 12'(GAP_H);
  localparam logic [9:0]  GMIN = 10'(GAP_MIN_Y);
  localparam logic [9:0]  GRST = 10'(GAP_MIN_Y + RANGE / 2);
  localparam logic [7:0]  RNG  = 8'(RANGE);

  flappy_pkg::state_e state_q;

  logic [TICK_BITS-1:0] tick_q;
  logic [7:0]           score_q;
  logic [7:0]           score_d;
  logic                 coll_q;
  logic [15:0]          lfsr;
  logic [NUM_PIPES-1:0] hit;
  logic [NUM_PIPES-1:0] pass;
  logic                 adv;
  logic [9:0]           gap_new;
  logic                 unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:8];

  assign adv = (state_q == flappy_pkg::RUN) && alive
            && (tick_q == '0);

  // Every pipe respawning on this step shares one gap.
  assign gap_new = GMIN
    + {2'b00, flappy_pkg::gap_off(lfsr[7:0], RNG)};

  for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
    logic [10:0] x_q;
    logic [9:0]  g_q;
    logic [11:0] xe;
    logic [11:0] xr;
    logic [11:0] ge;
    logic [11:0] by;
    logic [10:0] x_nx;
    logic        wrap;

    assign xe   = {1'b0, x_q};
    assign xr   = xe + PW;
    assign ge   = {2'b00, g_q};
    assign by   = {2'b00, bird_y};
    assign wrap = xe < SPD;
    assign x_nx = 11'(wrap ? xe - SPD + WRAP : xe - SPD);

    // A respawning pipe is far left of the bird already.
    assign pass[k] = (xr > BX) && (xr - SPD <= BX);

    assign hit[k] = (BX < xr) && (xe < BXR)
                 && ((by < ge) || (by + SH > ge + GH));

    always_ff @(posedge clk) begin
      if (reset) begin
        x_q <= 11'(SCREEN_W + k * PIPE_SPACING);
        g_q <= GRST;
      end else if (adv) begin
        x_q <= x_nx;
        if (wrap) begin
          g_q <= gap_new;
        end
      end
    end

    assign pipe_x[11*k +: 11] = x_q;
    assign gap_y[10*k +: 10]  = g_q;
  end

  always_comb begin
    logic [2:0] npass;
    logic [8:0] tot;
    npass = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      npass = npass + 3'(pass[k]);
    end
    tot     = {1'b0, score_q} + {6'b0, npass};
    score_d = tot[8] ? 8'hFF : tot[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= flappy_pkg::IDLE;
      tick_q  <= '0;
      score_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      tick_q <= tick_q + TICK_BITS'(1);
      unique case (state_q)
        flappy_pkg::IDLE: begin
          coll_q <= 1'b0;
          if (alive) begin
            state_q <= flappy_pkg::RUN;
          end
        end
        flappy_pkg::RUN: begin
          coll_q <= |hit;
          if (!alive) begin
            state_q <= flappy_pkg::FROZEN;
          end else if (tick_q == '0) begin
            score_q <= score_d;
          end
        end
        flappy_pkg::FROZEN: begin
        end
        default: state_q <= flappy_pkg::IDLE;
      endcase
    end
  end

  assign collision = coll_q;
  assign score     = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field: a slow-step
// instance for geometry, a fast one for saturation.
module tb_pipe_field;

  logic        clk = 1'b0;
  logic        reset;
  logic        alive;
  logic        alive2;
  logic [9:0]  bird_y;
  logic [9:0]  bird_y2;
  logic        coll1;
  logic        coll2;
  logic [32:0] pipe_x1;
  logic [32:0] pipe_x2;
  logic [29:0] gap_y1;
  logic [29:0] gap_y2;
  logic [7:0]  score1;
  logic [7:0]  score2;

  always #5 clk = ~clk;

  pipe_field #(.TICK_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .alive     (alive),
    .bird_y    (bird_y),
    .collision (coll1),
    .pipe_x    (pipe_x1),
    .gap_y     (gap_y1),
    .score     (score1)
  );

  pipe_field #(.TICK_BITS(1), .SCROLL_SPEED(8)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .alive     (alive2),
    .bird_y    (bird_y2),
    .collision (coll2),
    .pipe_x    (pipe_x2),
    .gap_y     (gap_y2),
    .score     (score2)
  );

  typedef struct {
    bit          do_wait;
    logic [10:0] wx;
    logic [9:0]  by;
    logic        coll;
    logic [7:0]  score;
  } vec_t;

  vec_t tbl [14];

  int nvec = 0;
  int nfail = 0;
  int respawns = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int prev2 [3];

  function automatic int x1(input int k);
    return int'(pipe_x1[11*k +: 11]);
  endfunction

  function automatic int g1(input int k);
    return int'(gap_y1[10*k +: 10]);
  endfunction

  function automatic int x2(input int k);
    return int'(pipe_x2[11*k +: 11]);
  endfunction

  function automatic int g2(input int k);
    return int'(gap_y2[10*k +: 10]);
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_x(input int k, input int v,
                        input int lim);
    int n = 0;
    while (x1(k) != v && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (x1(k) != v) begin
      nvec++;
      nfail++;
      $display("FAIL wait_x%0d: timeout at %0d, want %0d",
               k, x1(k), v);
    end
  endtask

  always @(posedge clk) cyc++;

  // Fast instance: every respawn must land in range.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_en && x2(k) > prev2[k]) begin
        respawns++;
        chk("dut2 respawn gap ok",
            int'(g2(k) >= 60 && g2(k) <= 300), 1);
        chk("dut2 respawn x ok",
            int'(x2(k) >= 652 && x2(k) <= 659), 1);
      end
      prev2[k] = x2(k);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 11'd140, 10'd0,    1'b0, 8'd0};
    tbl[1]  = '{1'b1, 11'd134, 10'd0,    1'b0, 8'd0};
    tbl[2]  = '{1'b1, 11'd132, 10'd0,    1'b1, 8'd0};
    tbl[3]  = '{1'b1, 11'd90,  10'd0,    1'b1, 8'd0};
    tbl[4]  = '{1'b0, 11'd0,   10'd179,  1'b1, 8'd0};
    tbl[5]  = '{1'b0, 11'd0,   10'd180,  1'b0, 8'd0};
    tbl[6]  = '{1'b0, 11'd0,   10'd240,  1'b0, 8'd0};
    tbl[7]  = '{1'b0, 11'd0,   10'd276,  1'b0, 8'd0};
    tbl[8]  = '{1'b0, 11'd0,   10'd277,  1'b1, 8'd0};
    tbl[9]  = '{1'b0, 11'd0,   10'd150,  1'b1, 8'd0};
    tbl[10] = '{1'b0, 11'd0,   10'd200,  1'b0, 8'd0};
    tbl[11] = '{1'b0, 11'd0,   10'd1023, 1'b1, 8'd0};
    tbl[12] = '{1'b1, 11'd50,  10'd0,    1'b1, 8'd0};
    tbl[13] = '{1'b1, 11'd48,  10'd0,    1'b0, 8'd1};

    reset   = 1'b1;
    alive   = 1'b0;
    alive2  = 1'b0;
    bird_y  = '0;
    bird_y2 = '0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    alive2 = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Idle: nothing moves.
    repeat (100) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle x%0d", k), x1(k), 640 + 220 * k);
      chk($sformatf("idle gap%0d", k), g1(k), 180);
    end
    chk("idle coll", coll1, 0);
    chk("idle score", score1, 0);

    // Scroll rate.
    alive = 1'b1;
    wait_x(0, 638, 40);
    repeat (144) @(negedge clk);
    chk("x0 after 10 steps", x1(0), 620);

    // Overlap and scoring vectors.
    for (int i = 0; i < 14; i++) begin
      bird_y = tbl[i].by;
      if (tbl[i].do_wait) wait_x(0, int'(tbl[i].wx), 6000);
      @(negedge clk);
      chk($sformatf("vec%0d coll", i), coll1, tbl[i].coll);
      chk($sformatf("vec%0d score", i), score1, tbl[i].score);
    end
    chk("gap0 before respawn", g1(0), 180);

    // Respawn of pipe 0.
    wait_x(0, 0, 2000);
    wait_x(0, 658, 40);
    chk("respawn gap0 ok", int'(g1(0) >= 60 && g1(0) <= 300), 1);

    // Freeze while pipe 1 overlaps the bird.
    wait_x(1, 90, 1200);
    bird_y = 10'd0;
    @(negedge clk);
    alive = 1'b0;
    @(negedge clk);
    bird_y = 10'd200;
    repeat (80) @(negedge clk);
    chk("frozen x0", x1(0), 530);
    chk("frozen x1", x1(1), 90);
    chk("frozen x2", x1(2), 310);
    chk("frozen gap1", g1(1), 180);
    chk("frozen score", score1, 1);
    chk("frozen coll", coll1, 1);

    // Fast instance: score saturates.
    while (cyc < 17000) @(negedge clk);
    chk("dut2 score sat", score2, 255);
    chk("dut2 respawns seen", int'(respawns >= 200), 1);

    // Reset restores idle geometry.
    mon_en = 1'b0;
    reset  = 1'b1;
    alive2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst x%0d", k), x1(k), 640 + 220 * k);
      chk($sformatf("rst gap%0d", k), g1(k), 180);
      chk($sformatf("rst2 x%0d", k), x2(k), 640 + 220 * k);
    end
    chk("rst score", score1, 0);
    chk("rst coll", coll1, 0);
    chk("rst2 score", score2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
